mult_div_ctrl: RTL

Iterative signed multiply/divide engine with its own sequencing FSM, sitting between the CPU control unit and the HI/LO registers. The control unit issues a one-cycle start with an opcode and the A/B operands. The block runs a fixed-length shift-add (mult) or restoring shift-subtract (div) sequence. It then returns the 64-bit result together with a one-cycle HI/LO write strobe, or raises the divide-by-zero flag that the control unit routes to its exception path.

---
 rtl/mult_div_ctrl_if.sv | 26 ++
 rtl/mult_div_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl_if.sv
// Handshake/data bundle between the CPU control unit (master) and the
// iterative multiply/divide engine (slave).
interface mult_div_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              op;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              busy;
  logic              done;
  logic              hilo_write;
  logic              div0;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, hilo_write, div0, hi, lo
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, hilo_write, div0, hi, lo
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply (shift-add) / divide (restoring) engine.
// Sequence: IDLE -> RUN (DATA_W iterations on magnitudes) -> FIX (sign
// correction, result into hi/lo) -> DONE (one-cycle done/hilo_write pulse).
// Divide by zero skips straight to DONE with div0 and leaves hi/lo untouched.
// Optional feature macro: MULT_DIV_EARLY_OUT_EN -- zero operands jump
// straight to FIX, giving a 2-clock result of hi=lo=0.
module mult_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_ctrl_if.slave bus
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_op;
  logic                r_sa;      // dividend sign, gives remainder sign
  logic                r_neg;     // sign(a) ^ sign(b), gives product/quotient sign
  logic [2*DATA_W-1:0] r_mcand;   // multiplicand magnitude, shifted left each step
  logic [DATA_W:0]     r_bmag;    // multiplier (shifted right) or divisor (static)
  logic [2*DATA_W-1:0] r_acc;     // mult: product; div: {remainder, quotient}
  logic                r_busy;
  logic                r_done;
  logic                r_hw;
  logic                r_div0;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  // Magnitudes carry one extra bit so -2^(DATA_W-1) stays positive.
  logic              w_a_neg, w_b_neg;
  logic [DATA_W:0]   w_a_ext, w_b_ext, w_a_mag, w_b_mag;
  logic [DATA_W:0]   w_part;
  logic [DATA_W-1:0] w_sub;
  logic              w_ge;
  logic [2*DATA_W-1:0] w_div_next;
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0] w_quo_fix, w_rem_fix;

  assign w_a_neg = bus.a_in[DATA_W-1];
  assign w_b_neg = bus.b_in[DATA_W-1];
  assign w_a_ext = {w_a_neg, bus.a_in};
  assign w_b_ext = {w_b_neg, bus.b_in};
  assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

`ifdef MULT_DIV_EARLY_OUT_EN
  logic w_zero;
  assign w_zero = (bus.a_in == '0) || (!bus.op && bus.b_in == '0);
`endif

  // One restoring-divide step: shift the next dividend bit into the
  // partial remainder and subtract the divisor if it fits.
  always_comb begin
    w_part     = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
    w_ge       = (w_part >= r_bmag);
    w_sub      = w_part[DATA_W-1:0] - r_bmag[DATA_W-1:0];
    w_div_next = w_ge ? {w_sub, r_acc[DATA_W-2:0], 1'b1}
                      : {w_part[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
  end

  // Sign correction applied in FIX; division truncates toward zero.
  always_comb begin
    w_prod_fix = r_neg ? -r_acc : r_acc;
    w_quo_fix  = r_neg ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    w_rem_fix  = r_sa  ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
  end

  // Sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_sa    <= 1'b0;
      r_neg   <= 1'b0;
      r_mcand <= '0;
      r_bmag  <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hw    <= 1'b0;
      r_div0  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_hw   <= 1'b0;
          r_div0 <= 1'b0;
          if (bus.start) begin
            r_busy <= 1'b1;
            r_op   <= bus.op;
            r_cnt  <= '0;
            if (bus.op && bus.b_in == '0) begin
              r_div0  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_sa    <= w_a_neg;
              r_neg   <= w_a_neg ^ w_b_neg;
              r_mcand <= {{(DATA_W-1){1'b0}}, w_a_mag};
              r_bmag  <= w_b_mag;
              // Divide starts with the dividend magnitude in the quotient half.
              r_acc   <= bus.op ? {{DATA_W{1'b0}}, w_a_mag[DATA_W-1:0]} : '0;
`ifdef MULT_DIV_EARLY_OUT_EN
              if (w_zero) begin
                r_acc   <= '0;
                r_sa    <= 1'b0;
                r_neg   <= 1'b0;
                r_state <= S_FIX;
              end else begin
                r_state <= S_RUN;
              end
`else
              r_state <= S_RUN;
`endif
            end
          end
        end
        S_RUN: begin
          if (r_op) begin
            r_acc <= w_div_next;
          end else begin
            if (r_bmag[0]) r_acc <= r_acc + r_mcand;
            r_mcand <= r_mcand << 1;
            r_bmag  <= r_bmag >> 1;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_op) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
            r_lo <= w_prod_fix[DATA_W-1:0];
          end
          r_done  <= 1'b1;
          r_hw    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_hw    <= 1'b0;
          r_div0  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.hilo_write = r_hw;
  assign bus.div0       = r_div0;
  assign bus.hi         = r_hi;
  assign bus.lo         = r_lo;

endmodule
